calc_seq: RTL and testbench

CALC_SEQ -- requirements
Module: calc_seq

---
 rtl/calc_seq.sv | 205 ++++++++++++++++++++
 tb/tb_calc_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq.sv
// Sequential decimal calculator: keypad-style digit/operator entry, multi-cycle
// shift-add multiply and restoring divide, and a scanned BCD digit display.
module calc_seq #(
  parameter int NDIG = 8,
  parameter int W    = 27
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] cmd,
  input  logic       cmd_valid,
  output logic [1:0] status,
  output logic [3:0] data,
  output logic [3:0] pos,
  output logic       neg
);

  localparam int CW = $clog2(W + 1);

  localparam logic [3:0] CMD_ADD = 4'hA;
  localparam logic [3:0] CMD_SUB = 4'hB;
  localparam logic [3:0] CMD_MUL = 4'hC;
  localparam logic [3:0] CMD_DIV = 4'hD;
  localparam logic [3:0] CMD_EQ  = 4'hE;
  localparam logic [3:0] CMD_BS  = 4'hF;

  localparam logic [3:0] POS_LAST = 4'(NDIG - 1);

  function automatic logic [2*W-1:0] pow10(input int unsigned n);
    logic [2*W-1:0] p;
    p = (2*W)'(1);
    for (int unsigned i = 0; i < n; i++)
      p = (p << 3) + (p << 1);
    return p;
  endfunction

  localparam logic [2*W-1:0] LIMIT = pow10(NDIG);

  typedef enum logic [2:0] {
    ENTRY_A,
    ENTRY_B,
    EXEC,
    SHOW,
    ERR
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]   digits, rega, regb;
  logic [3:0]     op;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc, wa;
  logic [W-1:0]   wb;

  logic           accept, is_digit, is_op, is_eq, is_bs;
  logic [2*W-1:0] digits_ext, digit_cand;
  logic           digit_ok;
  logic [2*W-1:0] mul_acc_nxt;
  logic [W:0]     rem_sh, rem_nxt;
  logic           rem_ge;
  logic [W-1:0]   quo_nxt;
  logic           a_lt_b;
  logic [2*W-1:0] result;
  logic           exec_last, div_zero, overflow;
  logic [4*NDIG-1:0] bcd;

  always_comb begin
    accept     = cmd_valid && (state == ENTRY_A || state == ENTRY_B);
    is_digit   = (cmd <= 4'd9);
    is_op      = (cmd >= CMD_ADD) && (cmd <= CMD_DIV);
    is_eq      = (cmd == CMD_EQ);
    is_bs      = (cmd == CMD_BS);
    digits_ext = (2*W)'(digits);
    digit_cand = (digits_ext << 3) + (digits_ext << 1) + (2*W)'(cmd);
    digit_ok   = (digit_cand < LIMIT);
  end

  // Multiply: acc accumulates wa (multiplicand shifted left) for each set LSB of wb.
  // Divide: acc[W:0] is the partial remainder, wb shifts dividend out / quotient in.
  always_comb begin
    mul_acc_nxt = acc + (wb[0] ? wa : '0);
    rem_sh      = {acc[W-1:0], wb[W-1]};
    rem_ge      = (rem_sh >= {1'b0, regb});
    rem_nxt     = rem_ge ? (rem_sh - {1'b0, regb}) : rem_sh;
    quo_nxt     = {wb[W-2:0], rem_ge};
    a_lt_b      = (rega < regb);
    unique case (op)
      CMD_ADD: result = (2*W)'(rega) + (2*W)'(regb);
      CMD_SUB: result = a_lt_b ? (2*W)'(regb - rega) : (2*W)'(rega - regb);
      CMD_MUL: result = mul_acc_nxt;
      default: result = (2*W)'(quo_nxt);
    endcase
    exec_last = !(op == CMD_MUL || op == CMD_DIV) || (cnt == CW'(W - 1));
    div_zero  = (op == CMD_DIV) && (regb == '0);
    overflow  = (result >= LIMIT);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ENTRY_A: if (accept && is_op) state_nxt = ENTRY_B;
      ENTRY_B: begin
        if (accept && is_op)      state_nxt = ERR;
        else if (accept && is_eq) state_nxt = EXEC;
      end
      EXEC: begin
        if (div_zero)       state_nxt = ERR;
        else if (exec_last) state_nxt = overflow ? ERR : SHOW;
      end
      SHOW:    if (pos == POS_LAST) state_nxt = ENTRY_A;
      default: state_nxt = ERR;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ENTRY_A;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digits <= '0;
      rega   <= '0;
      regb   <= '0;
      op     <= '0;
      cnt    <= '0;
      acc    <= '0;
      wa     <= '0;
      wb     <= '0;
      pos    <= '0;
      neg    <= 1'b0;
    end else begin
      unique case (state)
        ENTRY_A, ENTRY_B: begin
          pos <= (pos == POS_LAST) ? '0 : pos + 4'd1;
          if (accept) begin
            if (is_digit) begin
              if (digit_ok) digits <= digit_cand[W-1:0];
            end else if (is_bs) begin
              digits <= digits / W'(10);
            end else if (is_op && state == ENTRY_A) begin
              rega   <= digits;
              op     <= cmd;
              digits <= '0;
              neg    <= 1'b0;
            end else if (is_eq && state == ENTRY_B) begin
              regb <= digits;
              cnt  <= '0;
              pos  <= '0;
              acc  <= '0;
              wa   <= (2*W)'(rega);
              wb   <= (op == CMD_DIV) ? rega : digits;
            end
          end
        end
        EXEC: begin
          cnt <= cnt + CW'(1);
          if (op == CMD_MUL) begin
            acc <= mul_acc_nxt;
            wa  <= wa << 1;
            wb  <= wb >> 1;
          end else if (op == CMD_DIV) begin
            acc <= (2*W)'(rem_nxt);
            wb  <= quo_nxt;
          end
          if (exec_last && !div_zero && !overflow) begin
            digits <= result[W-1:0];
            neg    <= (op == CMD_SUB) && a_lt_b;
          end
        end
        SHOW:    pos <= (pos == POS_LAST) ? '0 : pos + 4'd1;
        default: ;
      endcase
      if (state_nxt == ERR) begin
        digits <= '0;
        neg    <= 1'b0;
        pos    <= '0;
      end
    end
  end

  // Combinational double-dabble so data tracks digits within the same cycle.
  always_comb begin
    bcd = '0;
    for (int unsigned i = 0; i < W; i++) begin
      for (int unsigned j = 0; j < NDIG; j++)
        if (bcd[4*j +: 4] >= 4'd5) bcd[4*j +: 4] = bcd[4*j +: 4] + 4'd3;
      bcd = {bcd[4*NDIG-2:0], digits[W-1-i]};
    end
  end

  always_comb begin
    status = 2'b10;
    data   = '0;
    unique case (state)
      ENTRY_A, ENTRY_B: data = bcd[4*pos +: 4];
      SHOW: begin
        status = 2'b01;
        data   = bcd[4*pos +: 4];
      end
      EXEC:    status = 2'b01;
      default: status = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_calc_seq.sv
// Directed bench for calc_seq: entry, arithmetic, display scan, errors and reset.
module tb_calc_seq;

  logic       clock;
  logic       reset;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic [1:0] status;
  logic [3:0] data;
  logic [3:0] pos;
  logic       neg;

  int nchk;
  int nfail;

  calc_seq #(.NDIG(8), .W(27)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .status    (status),
    .data      (data),
    .pos       (pos),
    .neg       (neg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // All tasks start and end aligned to a falling edge.
  task automatic press(input logic [3:0] c);
    cmd       = c;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (status == 2'b01 && cycles < 200) begin
      cycles++;
      @(negedge clock);
    end
  endtask

  task automatic read_display(output longint val);
    int d[8];
    for (int i = 0; i < 8; i++) d[i] = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      d[pos[2:0]] = int'(data);
    end
    val = 0;
    for (int i = 7; i >= 0; i--) val = val * 10 + longint'(d[i]);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cmd = 4'h0;
    cmd_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    nchk++; if (status !== 2'b10) begin nfail++; $display("FAIL reset_status got %b want 10", status); end
    nchk++; if (pos !== 4'd0) begin nfail++; $display("FAIL reset_pos got %0d want 0", pos); end
    nchk++; if (data !== 4'd0) begin nfail++; $display("FAIL reset_data got %0d want 0", data); end
    nchk++; if (neg !== 1'b0) begin nfail++; $display("FAIL reset_neg got %b want 0", neg); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_add();
    int exp_d[8] = '{6, 4, 0, 0, 0, 0, 0, 0};
    longint v;
    int cyc;
    do_reset();
    press(4'h1); press(4'h2); press(4'hA); press(4'h3); press(4'h4);
    read_display(v);
    nchk++; if (v !== 34) begin nfail++; $display("FAIL add_operand_b got %0d want 34", v); end
    press(4'hE);
    nchk++; if (status !== 2'b01 || pos !== 4'd0 || data !== 4'd0)
      begin nfail++; $display("FAIL add_exec got st=%b pos=%0d data=%0d want 01/0/0", status, pos, data); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      nchk++; if (status !== 2'b01 || pos !== 4'(i) || data !== 4'(exp_d[i]))
        begin nfail++; $display("FAIL add_show[%0d] got st=%b pos=%0d data=%0d want 01/%0d/%0d", i, status, pos, data, i, exp_d[i]); end
    end
    @(negedge clock);
    nchk++; if (status !== 2'b10 || pos !== 4'd0 || data !== 4'd6)
      begin nfail++; $display("FAIL add_after got st=%b pos=%0d data=%0d want 10/0/6", status, pos, data); end
    // Chain the result as operand A: 46 + 4
    press(4'hA); press(4'h4); press(4'hE);
    wait_ready(cyc);
    nchk++; if (cyc !== 9) begin nfail++; $display("FAIL chain_busy got %0d want 9", cyc); end
    read_display(v);
    nchk++; if (v !== 50) begin nfail++; $display("FAIL chain_result got %0d want 50", v); end
  endtask

  task automatic test_sub();
    longint v;
    int cyc;
    do_reset();
    press(4'h5); press(4'hB); press(4'h9); press(4'hE);
    wait_ready(cyc);
    nchk++; if (cyc !== 9) begin nfail++; $display("FAIL sub_busy got %0d want 9", cyc); end
    nchk++; if (neg !== 1'b1) begin nfail++; $display("FAIL sub_neg got %b want 1", neg); end
    read_display(v);
    nchk++; if (v !== 4) begin nfail++; $display("FAIL sub_result got %0d want 4", v); end
    press(4'hA);
    nchk++; if (neg !== 1'b0 || status !== 2'b10)
      begin nfail++; $display("FAIL sub_neg_clear got neg=%b st=%b want 0/10", neg, status); end
    do_reset();
    press(4'h9); press(4'hB); press(4'h5); press(4'hE);
    wait_ready(cyc);
    read_display(v);
    nchk++; if (v !== 4 || neg !== 1'b0) begin nfail++; $display("FAIL sub_pos got %0d neg=%b want 4/0", v, neg); end
  endtask

  task automatic test_mul();
    longint v;
    int cyc;
    do_reset();
    press(4'h1); press(4'h2); press(4'h3); press(4'hC); press(4'h4); press(4'h5); press(4'hE);
    wait_ready(cyc);
    nchk++; if (cyc !== 35) begin nfail++; $display("FAIL mul_busy got %0d want 35", cyc); end
    nchk++; if (status !== 2'b10) begin nfail++; $display("FAIL mul_status got %b want 10", status); end
    read_display(v);
    nchk++; if (v !== 5535 || neg !== 1'b0) begin nfail++; $display("FAIL mul_result got %0d neg=%b want 5535/0", v, neg); end
  endtask

  task automatic test_div();
    longint v;
    int cyc;
    do_reset();
    press(4'h1); press(4'h0); press(4'h0); press(4'hD); press(4'h7); press(4'hE);
    wait_ready(cyc);
    nchk++; if (cyc !== 35) begin nfail++; $display("FAIL div_busy got %0d want 35", cyc); end
    read_display(v);
    nchk++; if (v !== 14) begin nfail++; $display("FAIL div_result got %0d want 14", v); end
    do_reset();
    press(4'h7); press(4'hD); press(4'h0); press(4'hE);
    nchk++; if (status !== 2'b01) begin nfail++; $display("FAIL div0_exec got %b want 01", status); end
    @(negedge clock);
    nchk++; if (status !== 2'b00) begin nfail++; $display("FAIL div0_err got %b want 00", status); end
    for (int i = 0; i < 4; i++) press(4'h3);
    nchk++; if (status !== 2'b00 || pos !== 4'd0 || data !== 4'd0 || neg !== 1'b0)
      begin nfail++; $display("FAIL div0_hold got st=%b pos=%0d data=%0d neg=%b want 00/0/0/0", status, pos, data, neg); end
    do_reset();
    nchk++; if (status !== 2'b10) begin nfail++; $display("FAIL div0_reset got %b want 10", status); end
  endtask

  task automatic test_overflow();
    longint v;
    int cyc;
    do_reset();
    for (int i = 0; i < 9; i++) press(4'h9);
    read_display(v);
    nchk++; if (v !== 99999999) begin nfail++; $display("FAIL ninth_digit got %0d want 99999999", v); end
    press(4'hC); press(4'h2); press(4'hE);
    wait_ready(cyc);
    nchk++; if (cyc !== 27 || status !== 2'b00)
      begin nfail++; $display("FAIL mul_ovf got busy=%0d st=%b want 27/00", cyc, status); end
    do_reset();
    for (int i = 0; i < 8; i++) press(4'h9);
    press(4'hA); press(4'h1); press(4'hE);
    wait_ready(cyc);
    nchk++; if (cyc !== 1 || status !== 2'b00)
      begin nfail++; $display("FAIL add_ovf got busy=%0d st=%b want 1/00", cyc, status); end
  endtask

  task automatic test_entry();
    longint v;
    int cyc;
    do_reset();
    press(4'h1); press(4'h2); press(4'h3); press(4'hF);
    read_display(v);
    nchk++; if (v !== 12) begin nfail++; $display("FAIL backspace got %0d want 12", v); end
    press(4'hA); press(4'hF); press(4'h3); press(4'hE);
    wait_ready(cyc);
    read_display(v);
    nchk++; if (v !== 15) begin nfail++; $display("FAIL bs_after_op got %0d want 15", v); end
    do_reset();
    press(4'h1); press(4'h2); press(4'hE);
    nchk++; if (status !== 2'b10) begin nfail++; $display("FAIL eq_in_a got %b want 10", status); end
    read_display(v);
    nchk++; if (v !== 12) begin nfail++; $display("FAIL eq_in_a_digits got %0d want 12", v); end
    press(4'hA); press(4'h3); press(4'hB);
    nchk++; if (status !== 2'b00) begin nfail++; $display("FAIL op_in_b got %b want 00", status); end
  endtask

  task automatic test_busy_and_abort();
    longint v;
    int cyc;
    do_reset();
    press(4'h1); press(4'h2); press(4'h3); press(4'hC); press(4'h4); press(4'h5); press(4'hE);
    cmd = 4'h9;
    cmd_valid = 1'b1;
    repeat (5) @(negedge clock);
    cmd = 4'hA;
    repeat (5) @(negedge clock);
    cmd_valid = 1'b0;
    wait_ready(cyc);
    nchk++; if (cyc !== 25) begin nfail++; $display("FAIL busy_ignore_len got %0d want 25", cyc); end
    read_display(v);
    nchk++; if (v !== 5535) begin nfail++; $display("FAIL busy_ignore_result got %0d want 5535", v); end
    do_reset();
    press(4'h9); press(4'h9); press(4'hC); press(4'h9); press(4'hE);
    repeat (10) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    nchk++; if (status !== 2'b10 || pos !== 4'd0 || data !== 4'd0 || neg !== 1'b0)
      begin nfail++; $display("FAIL abort got st=%b pos=%0d data=%0d neg=%b want 10/0/0/0", status, pos, data, neg); end
    @(negedge clock);
    reset = 1'b0;
    read_display(v);
    nchk++; if (v !== 0 || status !== 2'b10)
      begin nfail++; $display("FAIL abort_residual got %0d st=%b want 0/10", v, status); end
  endtask

  initial begin
    nchk  = 0;
    nfail = 0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_overflow();
    test_entry();
    test_busy_and_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
